uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter among NUM_REQ requesters, each presenting a 24-bit response frame.
- Round-robin arbitration picks one requester, latches its frame and drives the transmitter's trmt/tx_data/tx_done handshake, three bytes MSB first.
- Acknowledges the winning requester once all bytes are sent.
- Sits between command-processing logic and the UART transceiver; it is the transmit-side counterpart of the 24-bit command assembler.

---
 rtl/uart_tx_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ requesters.
//
// A round-robin arbiter picks one pending requester, latches its frame and
// sends the frame MSB byte first through the trmt/tx_data/tx_done handshake.
// The winner gets a one-cycle ack once its last byte is complete.
//
// Optional feature: define UART_ARB_CHKSUM_EN to append one checksum byte to
// each frame. The checksum is the bitwise NOT of the 8-bit modular sum of the
// frame bytes.
//
// Ports:
//   clk_i      system clock
//   rst_i      asynchronous active-high reset
//   req_i      per-requester request, held high until the matching ack
//   frame_i    flattened frames; requester i at [(i+1)*8*FRAME_BYTES-1 -: 8*FRAME_BYTES]
//   ack_o      one-cycle pulse to the requester whose frame finished
//   gnt_o      one-hot grant, high from grant through the ack cycle
//   busy_o     high whenever the arbiter is not idle
//   trmt_o     one-cycle transmit strobe to the UART
//   tx_data_o  byte to transmit, stable from trmt until tx_done
//   tx_done_i  UART byte-complete pulse
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned FRAME_BYTES = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ*8*FRAME_BYTES-1:0] frame_i,
  output logic [NUM_REQ-1:0]             ack_o,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic                           busy_o,
  output logic                           trmt_o,
  output logic [7:0]                     tx_data_o,
  input  logic                           tx_done_i
);

  localparam int unsigned FrameW = 8 * FRAME_BYTES;
  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW   = $clog2(FRAME_BYTES + 2);

`ifdef UART_ARB_CHKSUM_EN
  // The checksum pass follows the last frame byte.
  localparam logic [CntW-1:0] LastCnt = CntW'(FRAME_BYTES);
  localparam logic [CntW-1:0] ChkCnt  = CntW'(FRAME_BYTES - 1);
`else
  localparam logic [CntW-1:0] LastCnt = CntW'(FRAME_BYTES - 1);
`endif

  typedef enum logic [1:0] {StIdle, StSend, StWait, StAck} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     rr_q, rr_d;
  logic [IdxW-1:0]     win_q, win_d;
  logic [FrameW-1:0]   shift_q, shift_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                trmt_q, trmt_d;
  logic [7:0]          tx_data_q, tx_data_d;
`ifdef UART_ARB_CHKSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif

  logic                found;
  logic [IdxW-1:0]     arb_idx;
  logic [FrameW-1:0]   arb_frame;
  logic [FrameW-1:0]   shift_nx;

  // Round-robin pick: the first pass (descending) leaves the lowest requesting
  // index, used when nothing at or above rr_q is pending (wrap case). The
  // second pass overrides it with the lowest requesting index >= rr_q.
  always_comb begin
    found     = 1'b0;
    arb_idx   = '0;
    arb_frame = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        found   = 1'b1;
        arb_idx = IdxW'(i);
      end
    end
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_i[i] && (IdxW'(i) >= rr_q)) begin
        arb_idx = IdxW'(i);
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (arb_idx == IdxW'(i)) begin
        arb_frame = frame_i[i*FrameW +: FrameW];
      end
    end
  end

  assign shift_nx = shift_q << 8;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    win_d     = win_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    busy_d    = busy_q;
    trmt_d    = 1'b0;
    tx_data_d = tx_data_q;
`ifdef UART_ARB_CHKSUM_EN
    sum_d     = sum_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d        = StSend;
          win_d          = arb_idx;
          shift_d        = arb_frame;
          cnt_d          = '0;
          gnt_d          = '0;
          gnt_d[arb_idx] = 1'b1;
          busy_d         = 1'b1;
          trmt_d         = 1'b1;
          tx_data_d      = arb_frame[FrameW-1 -: 8];
`ifdef UART_ARB_CHKSUM_EN
          sum_d          = arb_frame[FrameW-1 -: 8];
`endif
        end
      end

      // tx_done during the strobe cycle belongs to no byte of ours; ignore it.
      StSend: state_d = StWait;

      StWait: begin
        if (tx_done_i) begin
          shift_d = shift_nx;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d      = StAck;
            ack_d[win_q] = 1'b1;
          end else begin
            state_d = StSend;
            trmt_d  = 1'b1;
`ifdef UART_ARB_CHKSUM_EN
            if (cnt_q == ChkCnt) begin
              tx_data_d = ~sum_q;
            end else begin
              tx_data_d = shift_nx[FrameW-1 -: 8];
              sum_d     = sum_q + shift_nx[FrameW-1 -: 8];
            end
`else
            tx_data_d = shift_nx[FrameW-1 -: 8];
`endif
          end
        end
      end

      StAck: begin
        state_d = StIdle;
        gnt_d   = '0;
        busy_d  = 1'b0;
        rr_d    = (win_q == IdxW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      rr_q      <= '0;
      win_q     <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
      trmt_q    <= 1'b0;
      tx_data_q <= 8'h00;
`ifdef UART_ARB_CHKSUM_EN
      sum_q     <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      win_q     <= win_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      trmt_q    <= trmt_d;
      tx_data_q <= tx_data_d;
`ifdef UART_ARB_CHKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign ack_o     = ack_q;
  assign gnt_o     = gnt_q;
  assign busy_o    = busy_q;
  assign trmt_o    = trmt_q;
  assign tx_data_o = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: randomized requests against a reference
// model, scoreboard queue of expected bytes/acks popped by a monitor.
module tb_uart_tx_arbiter;
  localparam int NR = 2;
  localparam int FB = 3;
  localparam int FW = 8 * FB;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*FW-1:0] frame;
  logic [NR-1:0]    ack;
  logic [NR-1:0]    gnt;
  logic             busy;
  logic             trmt;
  logic [7:0]       tx_data;
  logic             tx_done;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ     (NR),
    .FRAME_BYTES (FB)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .frame_i   (frame),
    .ack_o     (ack),
    .gnt_o     (gnt),
    .busy_o    (busy),
    .trmt_o    (trmt),
    .tx_data_o (tx_data),
    .tx_done_i (tx_done)
  );

  typedef struct {
    bit         is_ack;
    logic [7:0] data;
    int         id;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  int         checks = 0;
  int         passes = 0;
  int         cyc = 0;
  int         last_done = -100;
  int         m_rr = 0;
  int         dly_min = 20;
  int         dly_max = 20;
  bit         spur_en = 1'b0;
  int         u_cnt = 0;
  logic [7:0] last_tx = 8'h00;
  bit         prev_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic void push_frame(input int id, input logic [FW-1:0] f);
    logic [7:0] sum = 8'h00;
    exp_t e;
    for (int b = 0; b < FB; b++) begin
      e.is_ack = 1'b0;
      e.data   = f[8*(FB-1-b) +: 8];
      e.id     = id;
      sbq.push_back(e);
      sum = sum + e.data;
    end
`ifdef UART_ARB_CHKSUM_EN
    e.is_ack = 1'b0;
    e.data   = ~sum;
    e.id     = id;
    sbq.push_back(e);
`endif
    e.is_ack = 1'b1;
    e.data   = 8'h00;
    e.id     = id;
    sbq.push_back(e);
  endfunction

  // First requesting index at or after the round-robin pointer, with wrap.
  function automatic int pick(input logic [NR-1:0] s);
    for (int k = 0; k < NR; k++) begin
      int idx = (m_rr + k) % NR;
      if (s[idx]) return idx;
    end
    return -1;
  endfunction

  // ---------------- UART model ----------------
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (rst) begin
        u_cnt = 0;
      end else if (trmt) begin
        u_cnt = int'($urandom_range(dly_max, dly_min));
        // Spurious pulse seen by the DUT in its strobe cycle.
        if (spur_en && $urandom_range(3) == 0) tx_done = 1'b1;
      end else if (u_cnt > 0) begin
        u_cnt--;
        if (u_cnt == 0) begin
          tx_done   = 1'b1;
          last_done = cyc;
        end
      end else if (!busy && spur_en && $urandom_range(5) == 0) begin
        tx_done = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("gnt_onehot0", 32'($onehot0(gnt)), 1);
        if (prev_ack) check("busy_after_ack", busy, 0);
        if (trmt) begin
          if (sbq.size() == 0) begin
            check("unexpected_trmt", 1, 0);
          end else begin
            mon_e = sbq.pop_front();
            check("kind_at_trmt", mon_e.is_ack, 0);
            check("tx_data", tx_data, mon_e.data);
            check("gnt_at_trmt", gnt, 1 << mon_e.id);
          end
          last_tx = tx_data;
        end else if (busy && ack == '0) begin
          check("tx_data_hold", tx_data, last_tx);
        end
        if (ack != '0) begin
          if (sbq.size() == 0) begin
            check("unexpected_ack", 1, 0);
          end else begin
            mon_e = sbq.pop_front();
            check("kind_at_ack", mon_e.is_ack, 1);
            check("ack", ack, 1 << mon_e.id);
            check("gnt_at_ack", gnt, 1 << mon_e.id);
            check("ack_latency", cyc, last_done + 1);
          end
        end
        prev_ack = (ack != '0);
      end else begin
        prev_ack = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int t = 0;
    while (busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (busy) check("idle_timeout", busy, 0);
  endtask

  // hold_frames > 0: requesters in s keep req high for that many frames total.
  task automatic run_round(input logic [NR-1:0] s, input int hold_frames, input bit perturb);
    logic [NR-1:0] left = s;
    int need;
    int acks = 0;
    int t = 0;
    int w;
    wait_idle();
    if (hold_frames > 0) begin
      need = hold_frames;
      for (int n = 0; n < hold_frames; n++) begin
        w = pick(s);
        push_frame(w, frame[w*FW +: FW]);
        m_rr = (w + 1) % NR;
      end
    end else begin
      need = $countones(s);
      while (left != '0) begin
        w = pick(left);
        push_frame(w, frame[w*FW +: FW]);
        left[w] = 1'b0;
        m_rr = (w + 1) % NR;
      end
    end
    req = s;
    @(negedge clk);
    check("grant_latency_trmt", trmt, 1);
    check("grant_latency_busy", busy, 1);
    while (acks < need && t < 5000) begin
      if (perturb && trmt) begin
        for (int i = 0; i < NR; i++) begin
          if (gnt[i] && req[i]) begin
            frame[i*FW +: FW] = FW'($urandom);
            req[i] = 1'b0;
          end
        end
      end
      if (ack != '0) begin
        acks++;
        if (hold_frames == 0) req = req & ~ack;
        else if (acks == need) req = '0;
      end
      t++;
      if (acks < need) @(negedge clk);
    end
    if (acks < need) begin
      check("round_timeout", acks, need);
      sbq.delete();
      req = '0;
    end
    @(negedge clk);
  endtask

  task automatic reset_mid_op();
    int ntr = 0;
    int t = 0;
    spur_en = 1'b0;
    dly_min = 20;
    dly_max = 20;
    wait_idle();
    frame[0 +: FW] = FW'($urandom);
    push_frame(0, frame[0 +: FW]);
    req = NR'(1);
    while (ntr < 2 && t < 500) begin
      @(negedge clk);
      if (trmt) ntr++;
      t++;
    end
    if (ntr < 2) check("rst_test_start", ntr, 2);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    sbq.delete();
    #1;
    check("midrst_ack", ack, 0);
    check("midrst_gnt", gnt, 0);
    check("midrst_busy", busy, 0);
    check("midrst_trmt", trmt, 0);
    check("midrst_tx_data", tx_data, 0);
    req  = '0;
    m_rr = 0;
    @(negedge clk);
    rst = 1'b0;
    frame[FW +: FW] = FW'($urandom);
    run_round(NR'(2), 0, 1'b0);
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    frame = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_trmt", trmt, 0);
    check("rst_tx_data", tx_data, 0);

    // Simultaneous requests right at reset exit.
    frame[0 +: FW]  = 24'hAAAAAA;
    frame[FW +: FW] = 24'h123456;
    rst = 1'b0;
    run_round(NR'(3), 0, 1'b0);

    // Single request.
    frame[0 +: FW] = 24'h550FF0;
    run_round(NR'(1), 0, 1'b0);

    // Fairness: both hold req for four frames.
    frame[0 +: FW]  = FW'($urandom);
    frame[FW +: FW] = FW'($urandom);
    run_round(NR'(3), 4, 1'b0);

    // Robustness: frame change and req drop mid-transfer, spurious tx_done.
    spur_en = 1'b1;
    frame[0 +: FW] = 24'h550FF0;
    run_round(NR'(1), 0, 1'b1);
    frame[0 +: FW]  = FW'($urandom);
    frame[FW +: FW] = FW'($urandom);
    run_round(NR'(3), 0, 1'b1);

    // Randomized rounds.
    for (int r = 0; r < 40; r++) begin
      logic [NR-1:0] s;
      int hold;
      bit pert;
      dly_min = 1;
      dly_max = int'($urandom_range(8, 1));
      spur_en = 1'($urandom_range(1));
      for (int i = 0; i < NR; i++) frame[i*FW +: FW] = FW'($urandom);
      s    = NR'($urandom_range((1 << NR) - 1, 1));
      hold = ($urandom_range(4) == 0) ? int'($urandom_range(4, 2)) : 0;
      pert = (hold == 0) && ($urandom_range(1) == 1);
      run_round(s, hold, pert);
    end

    reset_mid_op();

    check("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
